// File: rtl/usb_rx_data_buffer.sv
// rtl/usb_rx_data_buffer.sv - USB receive payload buffer with toggle tracking, commit/rollback and ACK/NAK request
// Build option: define USB_RXBUF_STATS_EN to add saturating ACK/NAK/error counters.
module usb_rx_data_buffer #(
    parameter int MAX_PACKET = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tog_clr_i,
    input  logic                  out_recv_i,
    input  logic [1:0]            out_type_i,
    input  logic                  out_tvalid_i,
    output logic                  out_tready_o,
    input  logic                  out_tlast_i,
    input  logic [7:0]            out_tdata_i,
    input  logic                  crc_err_i,
    output logic                  hsk_send_o,
    output logic [1:0]            hsk_type_o,
    input  logic                  hsk_done_i,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic [7:0]            m_tdata_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  ovf_o
`ifdef USB_RXBUF_STATS_EN
    ,
    output logic [7:0]            stat_ack_o,
    output logic [7:0]            stat_nak_o,
    output logic [7:0]            stat_err_o
`endif
);

    localparam int                  CW          = $clog2(MAX_PACKET + 1);
    localparam int                  DEPTH_N     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] MAX_ENTRIES = (ADDR_WIDTH + 1)'(MAX_PACKET);
    localparam logic [CW-1:0]       MAX_CNT     = CW'(MAX_PACKET);
    localparam logic [1:0]          PID_DATA0   = 2'b00;
    localparam logic [1:0]          PID_DATA1   = 2'b10;
    localparam logic [1:0]          HSK_ACK     = 2'b00;
    localparam logic [1:0]          HSK_NAK     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_CHECK, S_DROP, S_DROP_SILENT, S_HSK
    } state_t;

    state_t              state;
    logic [8:0]          mem [0:DEPTH_N-1];
    logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr;
    logic [ADDR_WIDTH:0] used, free;
    logic [CW-1:0]       byte_cnt;
    logic [1:0]          pid;
    logic                crc_seen, exp_tog;
    logic                start, room, crc_now, pid_bad, pid_match;
    logic                byte_take, overflow, mem_we, pop;
    logic [8:0]          rd_entry;

    assign used      = wr_commit - rd_ptr;
    assign free      = DEPTH - used;
    assign room      = free >= MAX_ENTRIES;
    assign start     = out_recv_i && (state == S_IDLE || state == S_RECV);
    assign crc_now   = crc_seen | crc_err_i;
    assign pid_bad   = (pid != PID_DATA0) && (pid != PID_DATA1);
    assign pid_match = pid == {exp_tog, 1'b0};
    assign byte_take = (state == S_RECV) && !out_recv_i && out_tvalid_i;
    assign overflow  = byte_take && (byte_cnt == MAX_CNT);
    assign mem_we    = byte_take && !overflow;
    assign pop       = m_tvalid_o && m_tready_i;

    assign out_tready_o = state inside {S_RECV, S_DROP, S_DROP_SILENT};
    // Only committed entries are readable; speculative writes sit beyond wr_commit.
    assign m_tvalid_o   = rd_ptr != wr_commit;
    assign rd_entry     = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign m_tdata_o    = rd_entry[7:0];
    assign m_tlast_o    = rd_entry[8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_N; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {out_tlast_i, out_tdata_i};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            rd_ptr     <= '0;
            byte_cnt   <= '0;
            pid        <= '0;
            crc_seen   <= 1'b0;
            exp_tog    <= 1'b0;
            hsk_send_o <= 1'b0;
            hsk_type_o <= '0;
            ovf_o      <= 1'b0;
            level_o    <= '0;
        end else begin
            ovf_o    <= 1'b0;
            level_o  <= used;
            crc_seen <= crc_now;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // A new packet start also truncates one still in RECV.
            if (start) begin
                pid      <= out_type_i;
                crc_seen <= crc_err_i;
                byte_cnt <= '0;
                wr_ptr   <= wr_commit;
                state    <= room ? S_RECV : S_DROP;
            end else begin
                case (state)
                    S_RECV: begin
                        if (overflow) begin
                            ovf_o  <= 1'b1;
                            wr_ptr <= wr_commit;
                            state  <= out_tlast_i ? S_IDLE : S_DROP_SILENT;
                        end else begin
                            if (mem_we) begin
                                wr_ptr   <= wr_ptr + 1'b1;
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                            if (out_tlast_i) state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (crc_now || pid_bad) begin
                            wr_ptr <= wr_commit;
                            state  <= S_IDLE;
                        end else begin
                            hsk_send_o <= 1'b1;
                            hsk_type_o <= HSK_ACK;
                            state      <= S_HSK;
                            if (pid_match) begin
                                wr_commit <= wr_ptr;
                                exp_tog   <= ~exp_tog;
                            end else begin
                                wr_ptr <= wr_commit;
                            end
                        end
                    end
                    S_DROP: begin
                        if (out_tlast_i) begin
                            hsk_send_o <= 1'b1;
                            hsk_type_o <= HSK_NAK;
                            state      <= S_HSK;
                        end
                    end
                    S_DROP_SILENT: begin
                        if (out_tlast_i) state <= S_IDLE;
                    end
                    S_HSK: begin
                        if (hsk_done_i) begin
                            hsk_send_o <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
            // SETUP forces DATA0 even over a flip in the same cycle.
            if (tog_clr_i) exp_tog <= 1'b0;
        end
    end

`ifdef USB_RXBUF_STATS_EN
    logic ack_req, nak_req, err_evt;

    assign ack_req = (state == S_CHECK) && !crc_now && !pid_bad;
    assign nak_req = (state == S_DROP) && !out_recv_i && out_tlast_i;
    assign err_evt = ((state == S_CHECK) && (crc_now || pid_bad)) || overflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_ack_o <= '0;
            stat_nak_o <= '0;
            stat_err_o <= '0;
        end else begin
            if (ack_req && stat_ack_o != 8'hFF) stat_ack_o <= stat_ack_o + 1'b1;
            if (nak_req && stat_nak_o != 8'hFF) stat_nak_o <= stat_nak_o + 1'b1;
            if (err_evt && stat_err_o != 8'hFF) stat_err_o <= stat_err_o + 1'b1;
        end
    end
`endif

endmodule
